// File: rtl/conv_div_pkg.sv
// conv_div_pkg: shared states, widths and saturation constants for the Conv divider
package conv_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W = 16;
    localparam int REM_W = 17;
    localparam int CNT_W = 5;
    localparam logic [DIVIDEND_W-1:0] QUO_POS_SAT = 32'h7FFF_FFFF;
    localparam logic [DIVIDEND_W-1:0] QUO_NEG_SAT = 32'h8000_0000;
endpackage

// File: rtl/conv_udiv_core.sv
// conv_udiv_core: unsigned radix-2 restoring shift/subtract datapath, one quotient bit per step
module conv_udiv_core
    import conv_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic [DIVIDEND_W-1:0] quo_o,
    output logic [REM_W-1:0]      rem_o
);
    logic [REM_W-1:0]      rem_q, rem_d, rem_sh;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [REM_W:0]        diff;
    // one iteration: shift the next dividend bit into the partial remainder, trial-subtract, restore on borrow
    always_comb begin
        rem_sh = {rem_q[REM_W-2:0], quo_q[DIVIDEND_W-1]};
        diff = {1'b0, rem_sh} - {2'b00, dvs_q};
        rem_d = step_i ? (diff[REM_W] ? rem_sh : diff[REM_W-1:0]) : rem_q;
        quo_d = step_i ? {quo_q[DIVIDEND_W-2:0], ~diff[REM_W]} : quo_q;
    end
    // operand capture on load, otherwise advance by one iteration when stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end
    assign quo_o = quo_q;
    assign rem_o = rem_q;
endmodule

// File: rtl/conv_sdiv_32s_16u.sv
// conv_sdiv_32s_16u: signed 32 / unsigned 16 iterative divider with block-level start/done handshake
module conv_sdiv_32s_16u
    import conv_div_pkg::*;
#(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd32,
    parameter int unsigned din1_WIDTH = 32'd16,
    parameter int unsigned dout_WIDTH = 32'd32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [REM_W-1:0]      rem,
    output logic                  div_zero
);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, zero_q, dz_q, dz_d, load, step;
    logic [DIVIDEND_W-1:0] abs_dividend, quo_mag, dout_q, dout_d;
    logic [REM_W-1:0]      rem_mag, rem_q, rem_d;
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign abs_dividend = din0[DIVIDEND_W-1] ? -din0 : din0;
    conv_udiv_core u_core (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .load_i    (load),
        .step_i    (step),
        .dividend_i(abs_dividend),
        .divisor_i (din1),
        .quo_o     (quo_mag),
        .rem_o     (rem_mag)
    );
    // FSM next state, iteration counter and sign/zero fixup of the results
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        load = 1'b0;
        step = 1'b0;
        dout_d = dout_q;
        rem_d = rem_q;
        dz_d = dz_q;
        case (state_q)
            IDLE: begin
                load = ap_start;
                cnt_d = ap_start ? CNT_W'(DIVIDEND_W - 1) : cnt_q;
                state_d = ap_start ? CALC : IDLE;
            end
            CALC: begin
                step = 1'b1;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
                dout_d = zero_q ? (neg_q ? QUO_NEG_SAT : QUO_POS_SAT) : (neg_q ? -quo_mag : quo_mag);
                rem_d = zero_q ? '0 : (neg_q ? -rem_mag : rem_mag);
                dz_d = zero_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, counter, captured operand flags and held results
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            neg_q <= 1'b0;
            zero_q <= 1'b0;
            dout_q <= '0;
            rem_q <= '0;
            dz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (load) begin
                neg_q <= din0[DIVIDEND_W-1];
                zero_q <= (din1 == '0);
            end
            dout_q <= dout_d;
            rem_q <= rem_d;
            dz_q <= dz_d;
        end
    end
    assign ap_idle = (state_q == IDLE);
    assign ap_ready = ap_idle & ap_start;
    assign ap_done = (state_q == DONE);
    assign dout = dout_q;
    assign rem = rem_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_conv_sdiv_32s_16u.sv
// tb_conv_sdiv_32s_16u: directed self-checking bench for the signed iterative divider
module tb_conv_sdiv_32s_16u;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready, ap_idle, ap_done, div_zero;
    logic [31:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic [31:0] dout;
    logic [16:0] rem;
    int          total = 0;
    int          bad = 0;

    conv_sdiv_32s_16u dut (
        .ap_clk  (clk),
        .ap_rst  (rst),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_idle (ap_idle),
        .ap_done (ap_done),
        .din0    (din0),
        .din1    (din1),
        .dout    (dout),
        .rem     (rem),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // one start pulse; returns ap_ready seen in the capture cycle and cycles until ap_done (-1 if none)
    task automatic do_op(input logic [31:0] a, input logic [15:0] b, output logic rdy, output int lat);
        @(negedge clk);
        din0 = a;
        din1 = b;
        ap_start = 1'b1;
        #1 rdy = ap_ready;
        @(posedge clk);
        #1 ap_start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ap_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        total++; if (ap_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        total++; if (ap_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        total++; if (rem !== 17'h0) begin bad++; $display("FAIL reset_rem got=%h exp=0", rem); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic rdy;
        int lat;
        do_op(32'd100, 16'd7, rdy, lat);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", rdy); end
        total++; if (lat != 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        total++; if (dout !== 32'd14) begin bad++; $display("FAIL basic_dout got=%h exp=0000000e", dout); end
        total++; if (rem !== 17'd2) begin bad++; $display("FAIL basic_rem got=%h exp=00002", rem); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b exp=0", div_zero); end
    endtask

    task automatic test_negative();
        logic rdy;
        int lat;
        do_op(-32'sd100, 16'd7, rdy, lat);
        total++; if (lat != 34) begin bad++; $display("FAIL neg_latency got=%0d exp=34", lat); end
        total++; if (dout !== 32'hFFFF_FFF2) begin bad++; $display("FAIL neg_dout got=%h exp=fffffff2", dout); end
        total++; if (rem !== 17'h1FFFE) begin bad++; $display("FAIL neg_rem got=%h exp=1fffe", rem); end
    endtask

    task automatic test_bounds();
        logic rdy;
        int lat;
        do_op(32'h8000_0000, 16'd1, rdy, lat);
        total++; if (dout !== 32'h8000_0000) begin bad++; $display("FAIL minint_dout got=%h exp=80000000", dout); end
        total++; if (rem !== 17'h0) begin bad++; $display("FAIL minint_rem got=%h exp=00000", rem); end
        do_op(32'h7FFF_FFFF, 16'hFFFF, rdy, lat);
        total++; if (dout !== 32'd32768) begin bad++; $display("FAIL maxint_dout got=%h exp=00008000", dout); end
        total++; if (rem !== 17'd32767) begin bad++; $display("FAIL maxint_rem got=%h exp=07fff", rem); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL maxint_dz got=%b exp=0", div_zero); end
    endtask

    task automatic test_div_zero();
        logic rdy;
        int lat;
        do_op(32'd5, 16'd0, rdy, lat);
        total++; if (lat != 34) begin bad++; $display("FAIL dz_latency got=%0d exp=34", lat); end
        total++; if (dout !== 32'h7FFF_FFFF) begin bad++; $display("FAIL dz_pos_dout got=%h exp=7fffffff", dout); end
        total++; if (rem !== 17'h0) begin bad++; $display("FAIL dz_pos_rem got=%h exp=00000", rem); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_pos_flag got=%b exp=1", div_zero); end
        do_op(-32'sd5, 16'd0, rdy, lat);
        total++; if (dout !== 32'h8000_0000) begin bad++; $display("FAIL dz_neg_dout got=%h exp=80000000", dout); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_neg_flag got=%b exp=1", div_zero); end
    endtask

    task automatic test_abort();
        logic rdy;
        int lat;
        int dones = 0;
        @(negedge clk);
        din0 = 32'd100;
        din1 = 16'd7;
        ap_start = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", ap_idle); end
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL abort_dout got=%h exp=0", dout); end
        total++; if (rem !== 17'h0) begin bad++; $display("FAIL abort_rem got=%h exp=0", rem); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL abort_dz got=%b exp=0", div_zero); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ap_done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        do_op(32'd100, 16'd7, rdy, lat);
        total++; if (lat != 34) begin bad++; $display("FAIL abort_after_latency got=%0d exp=34", lat); end
        total++; if (dout !== 32'd14 || rem !== 17'd2) begin bad++; $display("FAIL abort_after_result got=%h/%h exp=0000000e/00002", dout, rem); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3];
        logic [16:0] exp_r [3];
        logic [31:0] prev_d;
        logic [16:0] prev_r;
        int readies = 0;
        int ready_off = 0;
        int ndone = 0;
        int unstable = 0;
        exp_q[0] = 32'd100;        exp_r[0] = 17'd0;
        exp_q[1] = 32'hFFFF_FFF1; exp_r[1] = 17'h1FFFC;
        exp_q[2] = 32'd255;        exp_r[2] = 17'd255;
        prev_d = dout;
        prev_r = rem;
        for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            if (i == 0) begin din0 = 32'd1000; din1 = 16'd10; end
            if (i == 5) begin din0 = -32'sd79; din1 = 16'd5; end
            if (i == 40) begin din0 = 32'd65535; din1 = 16'd256; end
            ap_start = (i < 100);
            #1;
            if (ap_ready) begin
                readies++;
                if (i % 35 != 0) ready_off++;
            end
            if (ap_done) begin
                if (ndone < 3) begin
                    total++;
                    if (dout !== exp_q[ndone] || rem !== exp_r[ndone]) begin
                        bad++;
                        $display("FAIL b2b_result%0d got=%h/%h exp=%h/%h", ndone, dout, rem, exp_q[ndone], exp_r[ndone]);
                    end
                end
                ndone++;
            end else if (dout !== prev_d || rem !== prev_r) begin
                unstable++;
            end
            prev_d = dout;
            prev_r = rem;
        end
        total++; if (readies != 3) begin bad++; $display("FAIL b2b_ready_count got=%0d exp=3", readies); end
        total++; if (ready_off != 0) begin bad++; $display("FAIL b2b_ready_spacing got=%0d exp=0", ready_off); end
        total++; if (ndone != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
        total++; if (unstable != 0) begin bad++; $display("FAIL b2b_stability got=%0d exp=0", unstable); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_bounds();
        test_div_zero();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
